// File: rtl/tone_i2s_serializer_if.sv
// Bundle between the note/volume stage and the tone serializer.
//   note_div   : square-wave half period in clk cycles, 0 = silence
//   audio_max  : signed sample used while the tone is in its high phase
//   audio_min  : signed sample used while the tone is in its low phase
//   audio_mclk : DAC master clock (clk/4)
//   audio_lrck : word select (clk/512), 0 = left, 1 = right
//   audio_sck  : serial bit clock (clk/16)
//   audio_sdin : serial data, MSB first, left-justified
//   frame_tick : one-cycle pulse when a new frame word has been latched
//   tone_phase : current square-wave phase
// The master modport belongs to the producer side; the slave modport belongs to the serializer.
interface tone_i2s_serializer_if #(
    parameter int unsigned NOTE_W   = 22,
    parameter int unsigned SAMPLE_W = 16
);
    logic [NOTE_W-1:0]   note_div;
    logic [SAMPLE_W-1:0] audio_max;
    logic [SAMPLE_W-1:0] audio_min;
    logic                audio_mclk;
    logic                audio_lrck;
    logic                audio_sck;
    logic                audio_sdin;
    logic                frame_tick;
    logic                tone_phase;

    modport master (
        output note_div, audio_max, audio_min,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick, tone_phase
    );

    modport slave (
        input  note_div, audio_max, audio_min,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick, tone_phase
    );
endinterface

// File: rtl/tone_i2s_serializer.sv
// Square-wave tone generator plus 16-bit left-justified stereo serializer for the audio DAC.
// Ports:
//   clk    : 100 MHz system clock
//   rst    : synchronous active-high reset
//   bus_io : tone_i2s_serializer_if slave (note_div/audio_max/audio_min in,
//            audio_mclk/lrck/sck/sdin, frame_tick, tone_phase out)
// All audio clocks are bits of one free-running 9-bit frame counter, so they stay phase-locked.
module tone_i2s_serializer #(
    parameter int unsigned NOTE_W   = 22,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    tone_i2s_serializer_if.slave   bus_io
);

    logic [8:0]          fcnt_q, fcnt_d;
    logic [NOTE_W-1:0]   note_lat_q, note_lat_d;
    logic [NOTE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic                tone_phase_q, tone_phase_d;
    logic [SAMPLE_W-1:0] frame_word_q, frame_word_d;
    logic                sdin_q, sdin_d;
    logic                frame_tick_q, frame_tick_d;
    logic [SAMPLE_W-1:0] sample;

    always_comb begin
        fcnt_d       = fcnt_q + 9'd1;
        note_lat_d   = note_lat_q;
        tone_cnt_d   = tone_cnt_q;
        tone_phase_d = tone_phase_q;
        frame_word_d = frame_word_q;
        frame_tick_d = 1'b0;

        // New divisors are only accepted at a half-period boundary so the tone never glitches.
        if (note_lat_q == '0) begin
            tone_cnt_d   = '0;
            tone_phase_d = 1'b0;
            note_lat_d   = bus_io.note_div;
        end else if (tone_cnt_q == note_lat_q - NOTE_W'(1)) begin
            tone_cnt_d   = '0;
            tone_phase_d = ~tone_phase_q;
            note_lat_d   = bus_io.note_div;
        end else begin
            tone_cnt_d   = tone_cnt_q + NOTE_W'(1);
        end

        // Uses the registered phase, so a toggle in the latch cycle latches the old phase.
        if (note_lat_q == '0) begin
            sample = '0;
        end else if (tone_phase_q) begin
            sample = bus_io.audio_max;
        end else begin
            sample = bus_io.audio_min;
        end

        if (fcnt_q == 9'd511) begin
            frame_word_d = sample;
            frame_tick_d = 1'b1;
        end

        // Look ahead at the next counter/word so sdin changes on the SCK falling edge,
        // including the first bit of a freshly latched word.
        sdin_d = frame_word_d[~fcnt_d[7:4]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q       <= '0;
            note_lat_q   <= '0;
            tone_cnt_q   <= '0;
            tone_phase_q <= 1'b0;
            frame_word_q <= '0;
            sdin_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            fcnt_q       <= fcnt_d;
            note_lat_q   <= note_lat_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_phase_q <= tone_phase_d;
            frame_word_q <= frame_word_d;
            sdin_q       <= sdin_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus_io.audio_mclk = fcnt_q[1];
    assign bus_io.audio_sck  = fcnt_q[3];
    assign bus_io.audio_lrck = fcnt_q[8];
    assign bus_io.audio_sdin = sdin_q;
    assign bus_io.frame_tick = frame_tick_q;
    assign bus_io.tone_phase = tone_phase_q;

endmodule

// File: tb/tb_tone_i2s_serializer.sv
module tb_tone_i2s_serializer;
    localparam int unsigned NOTE_W = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_i2s_serializer_if #(.NOTE_W(NOTE_W), .SAMPLE_W(16)) bus ();

    tone_i2s_serializer #(.NOTE_W(NOTE_W), .SAMPLE_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected frame words pushed by the reference model, captured words by the monitor.
    logic [15:0] exp_q[$];
    logic [31:0] got_q[$];

    // Reference model of counter, tone generator and frame latch.
    logic [8:0]        m_fcnt;
    logic [NOTE_W-1:0] m_lat;
    logic [NOTE_W-1:0] m_cnt;
    logic              m_phase;

    always @(posedge clk) begin
        if (rst) begin
            m_fcnt  <= '0;
            m_lat   <= '0;
            m_cnt   <= '0;
            m_phase <= 1'b0;
            exp_q.delete();
            exp_q.push_back(16'h0000);
        end else begin
            m_fcnt <= m_fcnt + 9'd1;
            if (m_fcnt == 9'd511)
                exp_q.push_back((m_lat == '0) ? 16'h0000 :
                                (m_phase ? bus.audio_max : bus.audio_min));
            if (m_lat == '0) begin
                m_cnt   <= '0;
                m_phase <= 1'b0;
                m_lat   <= bus.note_div;
            end else if (int'(m_cnt) + 1 == int'(m_lat)) begin
                m_cnt   <= '0;
                m_phase <= ~m_phase;
                m_lat   <= bus.note_div;
            end else begin
                m_cnt <= m_cnt + 1'b1;
            end
        end
    end

    // Monitor: sample sdin mid-bit (SCK high) and assemble left+right words of each frame.
    logic [31:0] shreg;
    int          nb;
    always @(negedge clk) begin
        if (rst) begin
            nb <= 0;
            got_q.delete();
        end else if (m_fcnt[3:0] == 4'd8) begin
            shreg <= {shreg[30:0], bus.audio_sdin};
            nb    <= (m_fcnt == 9'd8) ? 1 : nb + 1;
            if (m_fcnt == 9'd504 && nb == 31) got_q.push_back({shreg[30:0], bus.audio_sdin});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_toggle(output int n);
        logic p;
        p = bus.tone_phase;
        n = 0;
        while (bus.tone_phase == p && n < 5000) begin
            cyc(1);
            n++;
        end
        if (n >= 5000) n = -1;
    endtask

    task automatic test_reset();
        int n;
        bus.note_div  = 22'd1000;
        bus.audio_max = 16'h7FFF;
        bus.audio_min = 16'h8001;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1300);
        rst = 1'b1;
        cyc(1);
        checks++;
        if ({bus.audio_mclk, bus.audio_lrck, bus.audio_sck, bus.audio_sdin,
             bus.frame_tick, bus.tone_phase} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {bus.audio_mclk, bus.audio_lrck, bus.audio_sck, bus.audio_sdin,
                      bus.frame_tick, bus.tone_phase});
        end
        cyc(2);
        rst = 1'b0;
        n = 0;
        while (n < 600) begin
            cyc(1);
            n++;
            if (bus.frame_tick) break;
        end
        checks++;
        if (n !== 512) begin
            errors++;
            $display("FAIL first_tick_after_reset got %0d want 512", n);
        end
    endtask

    task automatic test_clocks();
        int mr[$], sr[$], lr[$];
        int nz;
        logic pm, ps, pl;
        logic [31:0] g;
        logic [15:0] e;
        bus.note_div = '0;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        pm = 0; ps = 0; pl = 0; nz = 0;
        for (int i = 1; i <= 1100; i++) begin
            cyc(1);
            if (bus.audio_mclk && !pm) mr.push_back(i);
            if (bus.audio_sck && !ps) sr.push_back(i);
            if (bus.audio_lrck && !pl) lr.push_back(i);
            if (bus.audio_sdin !== 1'b0) nz++;
            pm = bus.audio_mclk; ps = bus.audio_sck; pl = bus.audio_lrck;
        end
        checks++;
        if (mr.size() < 2 || mr[1] - mr[0] != 4) begin
            errors++;
            $display("FAIL mclk_period got %0d want 4", (mr.size() < 2) ? -1 : mr[1] - mr[0]);
        end
        checks++;
        if (sr.size() < 2 || sr[1] - sr[0] != 16) begin
            errors++;
            $display("FAIL sck_period got %0d want 16", (sr.size() < 2) ? -1 : sr[1] - sr[0]);
        end
        checks++;
        if (lr.size() < 1 || lr[0] != 256) begin
            errors++;
            $display("FAIL lrck_first_rise got %0d want 256", (lr.size() < 1) ? -1 : lr[0]);
        end
        checks++;
        if (lr.size() < 2 || lr[1] - lr[0] != 512) begin
            errors++;
            $display("FAIL lrck_period got %0d want 512", (lr.size() < 2) ? -1 : lr[1] - lr[0]);
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL silent_sdin got %0d ones want 0", nz);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== {e, e}) begin
                errors++;
                $display("FAIL frame_word_silent got %h want %h", g, {e, e});
            end
        end
    endtask

    task automatic test_tone_period();
        int n;
        bus.note_div = 22'd1000;
        n = 0;
        while (bus.tone_phase !== 1'b1 && n < 3000) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n !== 1001) begin
            errors++;
            $display("FAIL first_toggle got %0d want 1001", n);
        end
        wait_toggle(n);
        checks++;
        if (n !== 1000) begin
            errors++;
            $display("FAIL high_half got %0d want 1000", n);
        end
        wait_toggle(n);
        checks++;
        if (n !== 1000) begin
            errors++;
            $display("FAIL low_half got %0d want 1000", n);
        end
    endtask

    task automatic test_div_change();
        int n;
        cyc(200);
        bus.note_div = 22'd300;
        wait_toggle(n);
        checks++;
        if (n !== 800) begin
            errors++;
            $display("FAIL half_after_change got %0d want 800 (1000 total)", n + 200);
        end
        for (int k = 0; k < 2; k++) begin
            wait_toggle(n);
            checks++;
            if (n !== 300) begin
                errors++;
                $display("FAIL new_half_%0d got %0d want 300", k, n);
            end
        end
    endtask

    task automatic test_frame_data();
        int seen, frames;
        logic [31:0] g;
        logic [15:0] e;
        bus.audio_max = 16'hA5C3;
        bus.audio_min = 16'h0000;
        bus.note_div  = 22'd1500;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== {e, e}) begin
                errors++;
                $display("FAIL frame_word_pre got %h want %h", g, {e, e});
            end
        end
        cyc(512 * 10);
        seen = 0;
        frames = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            frames++;
            if (g == 32'hA5C3A5C3) seen++;
            checks++;
            if (g !== {e, e}) begin
                errors++;
                $display("FAIL frame_word_a5c3 got %h want %h", g, {e, e});
            end
        end
        checks++;
        if (seen == 0 || frames < 8) begin
            errors++;
            $display("FAIL a5c3_pattern got %0d hits in %0d frames want >0 hits in >=8", seen,
                     frames);
        end
        bus.audio_max = 16'h1234;
        bus.audio_min = 16'hFEDC;
        bus.note_div  = 22'd700;
        cyc(512 * 6);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== {e, e}) begin
                errors++;
                $display("FAIL frame_word_min_gt_max got %h want %h", g, {e, e});
            end
        end
    endtask

    task automatic test_silence();
        int n, ones;
        logic [31:0] g, last;
        logic [15:0] e;
        bus.note_div = 22'd1000;
        n = 0;
        for (int k = 0; k < 4 && !(bus.tone_phase === 1'b1 && n > 0); k++) wait_toggle(n);
        cyc(100);
        bus.note_div = '0;
        wait_toggle(n);
        checks++;
        if (n !== 900) begin
            errors++;
            $display("FAIL silence_completes_half got %0d want 900", n);
        end
        ones = 0;
        for (int i = 0; i < 1700; i++) begin
            cyc(1);
            if (bus.tone_phase !== 1'b0) ones++;
        end
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL silence_phase got %0d high cycles want 0", ones);
        end
        last = 32'hFFFF_FFFF;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            last = g;
            checks++;
            if (g !== {e, e}) begin
                errors++;
                $display("FAIL frame_word_silence got %h want %h", g, {e, e});
            end
        end
        checks++;
        if (last !== 32'h0) begin
            errors++;
            $display("FAIL silence_last_frame got %h want 00000000", last);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        while (!bus.frame_tick && n < 600) begin
            cyc(1);
            n++;
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1);
            checks++;
            if (bus.frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL tick_width got %b want 0", bus.frame_tick);
            end
            n = 1;
            while (!bus.frame_tick && n < 600) begin
                cyc(1);
                n++;
            end
            checks++;
            if (n !== 512) begin
                errors++;
                $display("FAIL tick_spacing_%0d got %0d want 512", k, n);
            end
        end
    endtask

    initial begin
        bus.note_div  = '0;
        bus.audio_max = '0;
        bus.audio_min = '0;
        test_reset();
        test_clocks();
        test_tone_period();
        test_div_change();
        test_frame_data();
        test_silence();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
